// File: rtl/gnss_code_buf_mc.sv
// Multi-channel GNSS spreading-code buffer: CPU loads 16-bit code words per channel,
// each channel streams its successor chip through a 2-stage sync-read pipeline.
module gnss_code_buf_mc #(
    parameter int NCH      = 4,
    parameter int CODEBITS = 12,
    parameter int OP_SEL   = 0,
    parameter int OP_DATA  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wrReg,
    input  logic [15:0]             op,
    input  logic [31:0]             tos,
    input  logic [NCH*CODEBITS-1:0] nchip,
    output logic [NCH-1:0]          code,
    output logic [NCH-1:0]          epoch,
    output logic [NCH-1:0]          loaded,
    output logic                    err
);

    localparam int WORDS = (2 ** CODEBITS) / 16;
    localparam int WAW   = CODEBITS - 3;
    localparam int LW    = CODEBITS + 1;
    localparam logic [LW-1:0]  LEN_MAX = LW'(2 ** CODEBITS);
    localparam logic [WAW-1:0] WA_FULL = WAW'(WORDS);
    localparam logic [4:0]     NCH5    = 5'(NCH);

    logic            sel_cmd;
    logic            dat_cmd;
    logic [3:0]      sel_ch;
    logic [LW-1:0]   sel_len;
    logic            sel_ok;
    logic            cur_full;
    logic            wr_ok;
    logic            err_d;
    logic [3:0]      cur_ch_q;
    logic            err_q;
    logic [WAW-1:0]  cur_waddr;
    logic [NCH*WAW-1:0] waddr_all;
    logic            unused_bits;

    assign sel_cmd  = wrReg & op[OP_SEL];
    assign dat_cmd  = wrReg & op[OP_DATA];
    assign sel_ch   = tos[3:0];
    assign sel_len  = tos[16 +: LW];
    assign sel_ok   = sel_cmd && ({1'b0, sel_ch} < NCH5) && (sel_len != '0) && (sel_len <= LEN_MAX);
    assign unused_bits = ^{op, tos};

    always_comb begin
        cur_waddr = '0;
        for (int c = 0; c < NCH; c++) begin
            if (cur_ch_q == 4'(c)) begin
                cur_waddr = waddr_all[c*WAW +: WAW];
            end
        end
    end

    // A data word is only accepted alone and while the channel still has room.
    assign cur_full = (cur_waddr == WA_FULL);
    assign wr_ok    = dat_cmd & ~sel_cmd & ~cur_full;
    assign err_d    = err_q | (sel_cmd & ~sel_ok) | (sel_cmd & dat_cmd) | (dat_cmd & ~sel_cmd & cur_full);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_ch_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (sel_ok) begin
                cur_ch_q <= sel_ch;
            end
            err_q <= err_d;
        end
    end

    assign err = err_q;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic                hit_sel;
        logic                hit_wr;
        logic [WAW-1:0]      waddr_q;
        logic [LW-1:0]       len_q;
        logic                loaded_q;
        logic [LW-1:0]       wend;
        logic [LW-1:0]       last;
        logic [CODEBITS-1:0] nchip_c;
        logic [CODEBITS-1:0] raddr_d;
        logic [CODEBITS-1:0] raddr_q;
        logic [CODEBITS-1:0] prev_q;
        logic [3:0]          bit_q;
        logic                en_q;
        logic                epoch_q;
        logic [15:0]         rd_word_q;
        logic [15:0]         mem [WORDS];

        assign hit_sel = sel_ok && (sel_ch == 4'(gi));
        assign hit_wr  = wr_ok && (cur_ch_q == 4'(gi));
        assign wend    = {waddr_q + 1'b1, 4'b0000};
        assign last    = len_q - 1'b1;
        assign nchip_c = nchip[gi*CODEBITS +: CODEBITS];
        assign raddr_d = ({1'b0, nchip_c} >= last) ? '0 : nchip_c + 1'b1;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                waddr_q  <= '0;
                len_q    <= LEN_MAX;
                loaded_q <= 1'b0;
            end else if (hit_sel) begin
                waddr_q  <= '0;
                len_q    <= sel_len;
                loaded_q <= 1'b0;
            end else if (hit_wr) begin
                waddr_q <= waddr_q + 1'b1;
                if (wend >= len_q) begin
                    loaded_q <= 1'b1;
                end
            end
        end

        // Memory has no reset so it maps onto block RAM; reads are read-first.
        always_ff @(posedge clk) begin
            if (hit_wr && rst_n) begin
                mem[waddr_q[WAW-2:0]] <= tos[15:0];
            end
            rd_word_q <= mem[raddr_q[CODEBITS-1:4]];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                raddr_q <= '0;
                bit_q   <= '0;
                en_q    <= 1'b0;
                prev_q  <= '0;
                epoch_q <= 1'b0;
            end else begin
                raddr_q <= raddr_d;
                bit_q   <= raddr_q[3:0];
                en_q    <= loaded_q;
                prev_q  <= nchip_c;
                epoch_q <= loaded_q && ({1'b0, prev_q} == last) && (nchip_c == '0) && (prev_q != nchip_c);
            end
        end

        assign waddr_all[gi*WAW +: WAW] = waddr_q;
        assign loaded[gi] = loaded_q;
        assign epoch[gi]  = epoch_q;
        assign code[gi]   = en_q & rd_word_q[bit_q];
    end

endmodule

// File: tb/tb_gnss_code_buf_mc.sv
// Directed + randomized bench for gnss_code_buf_mc against a chip-level reference model.
module tb_gnss_code_buf_mc;

    localparam int NCH     = 4;
    localparam int CB      = 12;
    localparam int CAP     = 4096;
    localparam int OP_SEL  = 0;
    localparam int OP_DATA = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wrReg;
    logic [15:0]       op;
    logic [31:0]       tos;
    logic [NCH*CB-1:0] nchip;
    logic [NCH-1:0]    code;
    logic [NCH-1:0]    epoch;
    logic [NCH-1:0]    loaded;
    logic              err;

    always #5 clk = ~clk;

    gnss_code_buf_mc #(
        .NCH(NCH), .CODEBITS(CB), .OP_SEL(OP_SEL), .OP_DATA(OP_DATA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wrReg(wrReg), .op(op), .tos(tos),
        .nchip(nchip), .code(code), .epoch(epoch), .loaded(loaded), .err(err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one bit per chip, lengths and fill counts as plain integers.
    bit             mem_m [NCH][CAP];
    int             len_m [NCH];
    int             words_m [NCH];
    bit [NCH-1:0]   loaded_m;
    int             cur_m;
    bit             err_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        cur_m    = 0;
        err_m    = 1'b0;
        loaded_m = '0;
        for (int c = 0; c < NCH; c++) begin
            len_m[c]   = CAP;
            words_m[c] = 0;
        end
    endtask

    function automatic int succ(input int c, input int n);
        return (n >= len_m[c] - 1) ? 0 : n + 1;
    endfunction

    function automatic logic [NCH-1:0] code_exp(input logic [NCH*CB-1:0] nv);
        logic [NCH-1:0] r;
        int n;
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            n = int'(nv[c*CB +: CB]);
            if (loaded_m[c]) r[c] = mem_m[c][succ(c, n)];
        end
        return r;
    endfunction

    function automatic logic [31:0] sel_word(input int ch, input int len);
        return (32'(len) << 16) | 32'(ch);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_reset();
        $display("reset loaded=%b err=%b code=%b epoch=%b", loaded, err, code, epoch);
    endtask

    task automatic cmd(input bit sel, input bit dat, input logic [31:0] d);
        int ch;
        int len;
        wrReg = 1'b1;
        op = '0;
        op[OP_SEL]  = sel;
        op[OP_DATA] = dat;
        tos = d;
        @(posedge clk); #1;
        wrReg = 1'b0;
        op = '0;
        tos = '0;
        if (sel) begin
            ch  = int'(d[3:0]);
            len = int'(d[28:16]);
            if (ch < NCH && len >= 1 && len <= CAP) begin
                cur_m = ch;
                words_m[ch] = 0;
                len_m[ch] = len;
                loaded_m[ch] = 1'b0;
            end else begin
                err_m = 1'b1;
            end
            if (dat) err_m = 1'b1;
        end else if (dat) begin
            if (words_m[cur_m] == CAP / 16) begin
                err_m = 1'b1;
            end else begin
                for (int j = 0; j < 16; j++) mem_m[cur_m][16*words_m[cur_m] + j] = d[j];
                words_m[cur_m]++;
                if (16 * words_m[cur_m] >= len_m[cur_m]) loaded_m[cur_m] = 1'b1;
            end
        end
        $display("cmd sel=%0d dat=%0d tos=%h loaded=%b err=%b", sel, dat, d, loaded, err);
    endtask

    // Holds nchip for cyc cycles, counts epoch[0] pulses, then checks code.
    task automatic hold(input logic [NCH*CB-1:0] nv, input int cyc, output int ep0);
        nchip = nv;
        ep0 = 0;
        repeat (cyc) begin
            @(negedge clk);
            ep0 += int'(epoch[0]);
        end
        $display("read nchip=%h code=%b epoch0_pulses=%0d", nv, code, ep0);
        chk("code", 32'(code), 32'(code_exp(nv)));
        @(posedge clk); #1;
    endtask

    task automatic rd_rand(input int n);
        logic [NCH*CB-1:0] nv;
        int ep;
        repeat (n) begin
            for (int c = 0; c < NCH; c++) nv[c*CB +: CB] = CB'($urandom_range(0, len_m[c] - 1));
            hold(nv, 3, ep);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_loaded"}, 32'(loaded), 32'(loaded_m));
        chk({tag, "_err"}, 32'(err), 32'(err_m));
    endtask

    initial begin
        int ep;
        int ep_total;
        logic [NCH*CB-1:0] nv;

        rst_n = 1'b0; wrReg = 1'b0; op = '0; tos = '0; nchip = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        chk_state("rst0");
        chk("rst0_code", 32'(code), 32'd0);
        chk("rst0_epoch", 32'(epoch), 32'd0);

        // Full-ish load with alternating pattern, length not a multiple of 16.
        cmd(1'b1, 1'b0, sel_word(0, 4092));
        for (int i = 0; i < 256; i++) begin
            cmd(1'b0, 1'b1, 32'h0000_A5A5);
            if (i == 254) chk("t1_loaded_255", 32'(loaded), 32'b0000);
        end
        chk("t1_loaded_256", 32'(loaded), 32'b0001);
        chk_state("t1");
        rd_rand(10);

        // Short code sweep with wrap and epoch counting.
        cmd(1'b1, 1'b0, sel_word(0, 20));
        chk_state("t2_sel");
        cmd(1'b0, 1'b1, 32'h0000_0001);
        cmd(1'b0, 1'b1, 32'h0000_000F);
        chk("t2_loaded", 32'(loaded), 32'b0001);
        nv = '0;
        nv[CB-1:0] = CB'(5);
        hold(nv, 4, ep);
        ep_total = 0;
        for (int p = 0; p < 2; p++) begin
            for (int n = 0; n < 20; n++) begin
                nv[CB-1:0] = CB'(n);
                hold(nv, 4, ep);
                ep_total += ep;
            end
        end
        nv[CB-1:0] = '0;
        hold(nv, 4, ep);
        ep_total += ep;
        hold(nv, 4, ep);
        ep_total += ep;
        chk("t2_epochs", 32'(ep_total), 32'd2);
        chk_state("t2_end");

        // Invalid selects must leave channel state untouched.
        cmd(1'b1, 1'b0, sel_word(1, 32));
        cmd(1'b0, 1'b1, 32'($urandom_range(0, 65535)));
        chk_state("t4_half");
        cmd(1'b1, 1'b0, sel_word(5, 32));
        chk_state("t4_badch");
        cmd(1'b1, 1'b0, sel_word(2, 0));
        chk_state("t4_len0");
        cmd(1'b1, 1'b0, sel_word(2, 4097));
        chk_state("t4_len4097");
        cmd(1'b0, 1'b1, 32'($urandom_range(0, 65535)));
        chk_state("t4_done");
        rd_rand(6);

        do_reset();
        chk_state("rst1");
        chk("rst1_code", 32'(code), 32'd0);

        // Overfill past capacity.
        cmd(1'b1, 1'b0, sel_word(3, 4096));
        for (int i = 0; i < 256; i++) cmd(1'b0, 1'b1, 32'($urandom_range(0, 65535)));
        chk_state("t3_256");
        cmd(1'b0, 1'b1, 32'($urandom_range(0, 65535)));
        chk_state("t3_257");
        nv = '0;
        nv[3*CB +: CB] = CB'(4094);
        hold(nv, 3, ep);
        nv[3*CB +: CB] = CB'(4095);
        hold(nv, 3, ep);
        rd_rand(8);

        // Select+Data collision, then two independent channels.
        do_reset();
        cmd(1'b1, 1'b1, sel_word(1, 32) | 32'h0000_ABC0);
        chk_state("t5_coll");
        cmd(1'b0, 1'b1, 32'($urandom_range(0, 65535)));
        cmd(1'b0, 1'b1, 32'($urandom_range(0, 65535)));
        cmd(1'b1, 1'b0, sel_word(2, 48));
        for (int i = 0; i < 3; i++) cmd(1'b0, 1'b1, 32'($urandom_range(0, 65535)));
        chk_state("t5_loaded");
        rd_rand(10);

        // Reset in the middle of a load, then reload from word 0.
        cmd(1'b1, 1'b0, sel_word(0, 4096));
        for (int i = 0; i < 10; i++) cmd(1'b0, 1'b1, 32'($urandom_range(0, 65535)));
        do_reset();
        chk_state("t6_rst");
        chk("t6_code", 32'(code), 32'd0);
        chk("t6_epoch", 32'(epoch), 32'd0);
        cmd(1'b1, 1'b0, sel_word(0, 4096));
        for (int i = 0; i < 256; i++) cmd(1'b0, 1'b1, 32'($urandom_range(0, 65535)));
        chk_state("t6_reload");
        rd_rand(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
